// File: rtl/gamma_lut_pipe.sv
// gamma_lut_pipe: 2-cycle pixel LUT with double-buffered table, bank swap deferred to frame start
module gamma_lut_pipe #(
  parameter int DATA_W   = 8,
  parameter int CHANNELS = 3
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       en,
  input  logic                       in_vsync,
  input  logic                       in_hsync,
  input  logic                       in_de,
  input  logic [CHANNELS*DATA_W-1:0] in_data,
  output logic                       out_vsync,
  output logic                       out_hsync,
  output logic                       out_de,
  output logic [CHANNELS*DATA_W-1:0] out_data,
  input  logic                       wr_en,
  input  logic [DATA_W-1:0]          wr_addr,
  input  logic [DATA_W-1:0]          wr_data,
  input  logic                       swap_req,
  output logic                       swap_pending,
  output logic                       active_bank
);
  localparam int W     = CHANNELS * DATA_W;
  localparam int DEPTH = 2 ** DATA_W;
  typedef enum logic {IDLE, ARMED} state_t;
  state_t state_q, state_d;
  logic active_q, active_d, vs_prev_q, frame_start, toggle, use_lut, s1_en_q;
  logic [1:0] loaded_q, loaded_d;
  logic [2:0] s1_sync_q, s2_sync_q;
  logic [W-1:0] s1_data_q, s2_data_q, lut_d;
  logic [DATA_W-1:0] mem_q [2][DEPTH];
  assign frame_start = in_vsync & ~vs_prev_q;
  always_ff @(posedge clk or posedge rst)
    if (rst) state_q <= IDLE;
    else state_q <= state_d;
  always_comb
    state_d = (state_q == IDLE) ? ((swap_req && !frame_start) ? ARMED : IDLE)
                                : (frame_start ? IDLE : ARMED);
  // A request coinciding with frame start swaps at once instead of arming
  always_comb begin
    toggle       = frame_start & ((state_q == ARMED) | swap_req);
    swap_pending = (state_q == ARMED);
  end
  assign active_d = active_q ^ toggle;
  assign loaded_d = loaded_q | (wr_en ? (active_q ? 2'b01 : 2'b10) : 2'b00);
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      active_q  <= 1'b0;
      loaded_q  <= 2'b00;
      vs_prev_q <= 1'b0;
      s1_en_q   <= 1'b0;
      s1_sync_q <= '0;
      s1_data_q <= '0;
      s2_sync_q <= '0;
      s2_data_q <= '0;
    end else begin
      active_q  <= active_d;
      loaded_q  <= loaded_d;
      vs_prev_q <= in_vsync;
      s1_en_q   <= en;
      s1_sync_q <= {in_vsync, in_hsync, in_de};
      s1_data_q <= in_data;
      s2_sync_q <= s1_sync_q;
      s2_data_q <= lut_d;
    end
  always_ff @(posedge clk)
    if (wr_en) mem_q[~active_q][wr_addr] <= wr_data;
  assign use_lut = s1_en_q & loaded_q[active_q];
  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    assign lut_d[c*DATA_W +: DATA_W] = use_lut ? mem_q[active_q][s1_data_q[c*DATA_W +: DATA_W]]
                                               : s1_data_q[c*DATA_W +: DATA_W];
  end
  assign {out_vsync, out_hsync, out_de} = s2_sync_q;
  assign out_data    = s2_data_q;
  assign active_bank = active_q;
endmodule

// File: tb/tb_gamma_lut_pipe.sv
// tb_gamma_lut_pipe: vector table, directed corner sequences and random stream vs a frame-level model
module tb_gamma_lut_pipe;
  logic clk, rst, en, in_vsync, in_hsync, in_de, wr_en, swap_req;
  logic [23:0] in_data;
  logic [7:0] wr_addr, wr_data;
  logic out_vsync, out_hsync, out_de, swap_pending, active_bank;
  logic [23:0] out_data;
  int checks = 0, errors = 0;

  gamma_lut_pipe #(.DATA_W(8), .CHANNELS(3)) dut (
    .clk(clk), .rst(rst), .en(en), .in_vsync(in_vsync), .in_hsync(in_hsync), .in_de(in_de),
    .in_data(in_data), .out_vsync(out_vsync), .out_hsync(out_hsync), .out_de(out_de),
    .out_data(out_data), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .swap_req(swap_req), .swap_pending(swap_pending), .active_bank(active_bank)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  bit [7:0] m_bank [2][256];
  bit m_loaded [2];
  bit m_active, m_armed, m_prev, p1_en;
  bit [23:0] p1_data;
  bit [2:0] p1_sync;

  typedef struct {
    logic en;
    logic [23:0] din;
    logic [23:0] exp;
  } vec_t;
  vec_t tbl [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic m_reset();
    m_loaded[0] = 0; m_loaded[1] = 0;
    m_active = 0; m_armed = 0; m_prev = 0;
    p1_en = 0; p1_data = 0; p1_sync = 0;
  endtask

  task automatic step();
    bit [23:0] e;
    bit [2:0] es;
    bit [7:0] x;
    bit fs;
    for (int c = 0; c < 3; c++) begin
      x = p1_data[c*8 +: 8];
      e[c*8 +: 8] = (p1_en && m_loaded[m_active]) ? m_bank[m_active][x] : x;
    end
    es = p1_sync;
    fs = in_vsync && !m_prev;
    if (wr_en) begin
      m_bank[!m_active][wr_addr] = wr_data;
      m_loaded[!m_active] = 1;
    end
    if (fs && (m_armed || swap_req)) begin
      m_active = !m_active;
      m_armed = 0;
    end else if (swap_req) m_armed = 1;
    m_prev = in_vsync;
    p1_en = en; p1_data = in_data; p1_sync = {in_vsync, in_hsync, in_de};
    @(posedge clk); #1;
    chk("data", out_data, e);
    chk("sync", {out_vsync, out_hsync, out_de}, es);
    chk("active", active_bank, m_active);
    chk("pending", swap_pending, m_armed);
  endtask

  initial begin
    tbl[0] = '{1'b1, 24'h102030, 24'hEFDFCF};
    tbl[1] = '{1'b0, 24'h102030, 24'h102030};
    tbl[2] = '{1'b1, 24'h00FF80, 24'hFF007F};
    tbl[3] = '{1'b0, 24'hABCDEF, 24'hABCDEF};
    tbl[4] = '{1'b1, 24'hABCDEF, 24'h543210};
    tbl[5] = '{1'b0, 24'h000000, 24'h000000};
    tbl[6] = '{1'b1, 24'h010203, 24'hFEFDFC};
    tbl[7] = '{1'b0, 24'hFFFFFF, 24'hFFFFFF};
    rst = 1; en = 0; in_vsync = 0; in_hsync = 0; in_de = 0; in_data = 0;
    wr_en = 0; wr_addr = 0; wr_data = 0; swap_req = 0;
    #1;
    chk("rst_data", out_data, 0);
    chk("rst_sync", {out_vsync, out_hsync, out_de}, 0);
    chk("rst_active", active_bank, 0);
    chk("rst_pending", swap_pending, 0);
    @(posedge clk); @(posedge clk); #1;
    rst = 0;
    m_reset();

    // reset pass-through
    en = 1; in_de = 1; in_data = 24'h123456;
    step(); step();
    chk("pass_data", out_data, 24'h123456);
    chk("pass_de", out_de, 1);
    chk("pass_active", active_bank, 0);

    // load bank 1 inverted, arm mid-frame
    in_data = 24'h101010;
    for (int a = 0; a < 256; a++) begin
      wr_en = 1; wr_addr = 8'(a); wr_data = 8'(255 - a);
      swap_req = (a == 128);
      step();
    end
    wr_en = 0; swap_req = 0;
    step();
    chk("armed_pending", swap_pending, 1);
    chk("armed_pass", out_data, 24'h101010);
    in_vsync = 1;
    step();
    chk("swap_active", active_bank, 1);
    chk("swap_pending", swap_pending, 0);
    step();
    chk("swap_lut", out_data, 24'hEFEFEF);

    // bypass alternation
    for (int i = 0; i < 8; i++) begin
      en = tbl[i].en; in_data = tbl[i].din;
      step();
      if (i > 0) chk("tbl", out_data, tbl[i-1].exp);
    end
    en = 0; in_data = 0;
    step();
    chk("tbl", out_data, tbl[7].exp);

    // shadow isolation: rewrite bank 0 while bank 1 is active
    en = 1; in_data = 24'h102030; in_vsync = 0;
    for (int a = 0; a < 256; a++) begin
      wr_en = 1; wr_addr = 8'(a); wr_data = 8'(a) ^ 8'h5A;
      step();
    end
    wr_en = 0;
    step();
    chk("iso_unchanged", out_data, 24'hEFDFCF);
    in_vsync = 1; swap_req = 1;
    step();
    chk("simul_active", active_bank, 0);
    chk("simul_pending", swap_pending, 0);
    swap_req = 0;
    step();
    chk("iso_new", out_data, 24'h4A7A6A);

    // double request while armed gives a single toggle
    in_vsync = 0;
    step();
    swap_req = 1; step();
    chk("dbl_pending", swap_pending, 1);
    step();
    swap_req = 0; in_vsync = 1;
    step();
    chk("dbl_active", active_bank, 1);
    chk("dbl_pending0", swap_pending, 0);
    step();
    chk("dbl_lut", out_data, 24'hEFDFCF);

    // reset while armed with bank 1 active
    swap_req = 1; step();
    swap_req = 0;
    chk("pre_rst_pending", swap_pending, 1);
    #2 rst = 1; #1;
    chk("mid_rst_data", out_data, 0);
    chk("mid_rst_de", out_de, 0);
    chk("mid_rst_active", active_bank, 0);
    chk("mid_rst_pending", swap_pending, 0);
    @(posedge clk); #1;
    rst = 0;
    m_reset();
    in_vsync = 0; in_data = 24'h0A0B0C; en = 1;
    step(); step();
    chk("post_rst_pass", out_data, 24'h0A0B0C);
    chk("post_rst_active", active_bank, 0);

    // randomized stream
    for (int i = 0; i < 3000; i++) begin
      en = 1'($urandom); in_de = 1'($urandom); in_hsync = 1'($urandom);
      in_data = 24'($urandom);
      if ($urandom_range(0, 19) == 0) in_vsync = ~in_vsync;
      wr_en = ($urandom_range(0, 3) == 0);
      wr_addr = 8'($urandom); wr_data = 8'($urandom);
      swap_req = ($urandom_range(0, 29) == 0);
      step();
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
